// File: rtl/image_pipe_core.sv
// Image pipe stream endpoint: saturating offset on ingest, DEPTH-entry FIFO,
// downstream stall handling, and per-frame pixel statistics.

module image_pipe_sat #(
  parameter int DW_IN  = 32,
  parameter int DW_OUT = 32
) (
  input  logic [DW_IN-1:0]  data,
  input  logic [DW_IN-1:0]  offset,
  output logic [DW_OUT-1:0] res
);
  localparam int SW = DW_IN + 1;
  localparam int MW = ((SW > DW_OUT) ? SW : DW_OUT) + 1;

  logic [SW-1:0] sum;
  logic [MW-1:0] sum_x, max_x;

  // Compare at a width that holds both the sum and the output ceiling.
  assign sum   = {1'b0, data} + {1'b0, offset};
  assign sum_x = MW'(sum);
  assign max_x = MW'({DW_OUT{1'b1}});
  assign res   = (sum_x > max_x) ? '1 : DW_OUT'(sum_x);
endmodule

module image_pipe_core #(
  parameter int               DW_IN  = 32,
  parameter int               DW_OUT = 32,
  parameter int               DEPTH  = 4,
  parameter logic [DW_IN-1:0] OFFSET = '0,
  parameter int               LEN_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW_IN-1:0]  is_data_in,
  input  logic              is_valid_in,
  input  logic              is_end_in,
  output logic              is_busy_out,
  output logic [DW_OUT-1:0] im_data_out,
  output logic              im_valid_out,
  output logic              im_end_out,
  input  logic              im_busy_in,
  output logic [15:0]       frame_cnt,
  output logic [LEN_W-1:0]  last_frame_len
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic              last;
    logic [DW_OUT-1:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [DW_OUT-1:0] sat_data;
  logic [LEN_W-1:0]  pix_cnt, pix_nxt;
  logic              push, pop;

  image_pipe_sat #(.DW_IN(DW_IN), .DW_OUT(DW_OUT)) u_sat (
    .data   (is_data_in),
    .offset (OFFSET),
    .res    (sat_data)
  );

  // Handshake flags decode registered occupancy only.
  assign is_busy_out  = (count == CW'(DEPTH));
  assign im_valid_out = (count != '0);
  assign push         = is_valid_in && !is_busy_out;
  assign pop          = im_valid_out && !im_busy_in;

  assign head        = mem[rd_ptr];
  assign im_data_out = im_valid_out ? head.data : '0;
  assign im_end_out  = im_valid_out ? head.last : 1'b0;

  // Storage is not reset; an empty FIFO masks whatever it holds.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{last: is_end_in, data: sat_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign pix_nxt = (pix_cnt == '1) ? pix_cnt : pix_cnt + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt        <= '0;
      frame_cnt      <= '0;
      last_frame_len <= '0;
    end else if (pop) begin
      if (im_end_out) begin
        last_frame_len <= pix_nxt;
        frame_cnt      <= frame_cnt + 16'd1;
        pix_cnt        <= '0;
      end else begin
        pix_cnt <= pix_nxt;
      end
    end
  end
endmodule

// File: tb/tb_image_pipe_core.sv
// Directed bench for image_pipe_core: default 32-bit instance plus an 8-bit
// instance with OFFSET=5 for the saturation cases.

module tb_image_pipe_core;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] is_data = 0;
  logic        is_valid = 0, is_end = 0, im_busy = 0;
  logic        is_busy, im_valid, im_end;
  logic [31:0] im_data;
  logic [15:0] frame_cnt;
  logic [23:0] last_len;

  logic [7:0]  s_data = 0;
  logic        s_valid = 0, s_end = 0;
  logic        s_busy, s_ovalid, s_oend;
  logic [7:0]  s_odata;
  logic [15:0] s_frame_cnt;
  logic [23:0] s_last_len;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  image_pipe_core dut (
    .clk(clk), .rst_n(rst_n),
    .is_data_in(is_data), .is_valid_in(is_valid), .is_end_in(is_end),
    .is_busy_out(is_busy),
    .im_data_out(im_data), .im_valid_out(im_valid), .im_end_out(im_end),
    .im_busy_in(im_busy),
    .frame_cnt(frame_cnt), .last_frame_len(last_len)
  );

  image_pipe_core #(.DW_IN(8), .DW_OUT(8), .OFFSET(8'd5)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .is_data_in(s_data), .is_valid_in(s_valid), .is_end_in(s_end),
    .is_busy_out(s_busy),
    .im_data_out(s_odata), .im_valid_out(s_ovalid), .im_end_out(s_oend),
    .im_busy_in(1'b0),
    .frame_cnt(s_frame_cnt), .last_frame_len(s_last_len)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (im_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", im_valid); end
    checks++; if (is_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", is_busy); end
    checks++; if (im_data !== 32'd0 || im_end !== 1'b0) begin errors++; $display("FAIL rst_data got=%h/%0b exp=0/0", im_data, im_end); end
    checks++; if (frame_cnt !== 16'd0 || last_len !== 24'd0) begin errors++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", frame_cnt, last_len); end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] beats [3];
    beats[0] = 32'h10; beats[1] = 32'h20; beats[2] = 32'h30;
    im_busy = 0;
    for (int i = 0; i < 3; i++) begin
      is_valid = 1; is_data = beats[i]; is_end = (i == 2);
      step();
      checks++; if (im_valid !== 1'b1 || im_data !== beats[i]) begin errors++; $display("FAIL basic_out%0d got=%0b/%h exp=1/%h", i, im_valid, im_data, beats[i]); end
      checks++; if (im_end !== (i == 2)) begin errors++; $display("FAIL basic_end%0d got=%0b exp=%0b", i, im_end, (i == 2)); end
      checks++; if (is_busy !== 1'b0) begin errors++; $display("FAIL basic_busy%0d got=%0b exp=0", i, is_busy); end
    end
    is_valid = 0; is_end = 0;
    step();
    checks++; if (im_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%0b exp=0", im_valid); end
    checks++; if (frame_cnt !== 16'd1 || last_len !== 24'd3) begin errors++; $display("FAIL basic_stats got=%0d/%0d exp=1/3", frame_cnt, last_len); end
  endtask

  task automatic test_saturate();
    logic [7:0] din [4];
    logic [7:0] dexp [4];
    din[0] = 8'hF0; din[1] = 8'hFA; din[2] = 8'hFF; din[3] = 8'h00;
    dexp[0] = 8'hF5; dexp[1] = 8'hFF; dexp[2] = 8'hFF; dexp[3] = 8'h05;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = din[i]; s_end = (i == 3);
      step();
      checks++; if (s_ovalid !== 1'b1 || s_odata !== dexp[i]) begin errors++; $display("FAIL sat%0d got=%0b/%h exp=1/%h", i, s_ovalid, s_odata, dexp[i]); end
    end
    s_valid = 0; s_end = 0;
    step();
    checks++; if (s_frame_cnt !== 16'd1 || s_last_len !== 24'd4) begin errors++; $display("FAIL sat_stats got=%0d/%0d exp=1/4", s_frame_cnt, s_last_len); end
  endtask

  task automatic test_backpressure();
    int in_idx, out_idx;
    logic will_push, will_pop;
    logic [31:0] popped;
    im_busy = 1;
    for (int i = 0; i < 4; i++) begin
      is_valid = 1; is_data = 32'h100 + i; is_end = 0;
      step();
      checks++; if (im_data !== 32'h100) begin errors++; $display("FAIL bp_head%0d got=%h exp=100", i, im_data); end
      checks++; if (is_busy !== (i == 3)) begin errors++; $display("FAIL bp_busy%0d got=%0b exp=%0b", i, is_busy, (i == 3)); end
    end
    is_data = 32'h104;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (is_busy !== 1'b1 || im_data !== 32'h100) begin errors++; $display("FAIL bp_hold%0d got=%0b/%h exp=1/100", i, is_busy, im_data); end
    end
    im_busy = 0;
    in_idx = 4; out_idx = 0;
    for (int cyc = 0; cyc < 30 && out_idx < 6; cyc++) begin
      is_valid = (in_idx < 6); is_data = 32'h100 + in_idx; is_end = (in_idx == 5);
      will_push = is_valid && !is_busy;
      will_pop  = im_valid && !im_busy;
      popped    = im_data;
      step();
      if (will_pop) begin
        checks++; if (popped !== 32'h100 + out_idx) begin errors++; $display("FAIL bp_order%0d got=%h exp=%h", out_idx, popped, 32'h100 + out_idx); end
        out_idx++;
      end
      if (will_push) in_idx++;
    end
    is_valid = 0; is_end = 0;
    checks++; if (out_idx !== 6 || im_valid !== 1'b0) begin errors++; $display("FAIL bp_count got=%0d/%0b exp=6/0", out_idx, im_valid); end
    checks++; if (frame_cnt !== 16'd2 || last_len !== 24'd6) begin errors++; $display("FAIL bp_stats got=%0d/%0d exp=2/6", frame_cnt, last_len); end
  endtask

  task automatic test_wrap();
    int in_idx, out_idx;
    logic will_push, will_pop;
    logic [31:0] popped;
    im_busy = 1;
    for (int i = 0; i < 4; i++) begin
      is_valid = 1; is_data = 32'h200 + i; is_end = 0;
      step();
    end
    in_idx = 4; out_idx = 0;
    for (int cyc = 0; cyc < 200 && out_idx < 20; cyc++) begin
      if (in_idx < 20) im_busy = ~im_busy;
      else im_busy = 0;
      is_valid = (in_idx < 20); is_data = 32'h200 + in_idx; is_end = (in_idx == 19);
      will_push = is_valid && !is_busy;
      will_pop  = im_valid && !im_busy;
      popped    = im_data;
      step();
      if (will_pop) begin
        checks++; if (popped !== 32'h200 + out_idx) begin errors++; $display("FAIL wrap_order%0d got=%h exp=%h", out_idx, popped, 32'h200 + out_idx); end
        out_idx++;
      end
      if (will_push) in_idx++;
      if (in_idx < 20) begin
        checks++; if (dut.count < 3 || dut.count > 4) begin errors++; $display("FAIL wrap_occ got=%0d exp=3..4", dut.count); end
      end
    end
    is_valid = 0; is_end = 0; im_busy = 0;
    checks++; if (out_idx !== 20) begin errors++; $display("FAIL wrap_count got=%0d exp=20", out_idx); end
    checks++; if (frame_cnt !== 16'd3 || last_len !== 24'd20) begin errors++; $display("FAIL wrap_stats got=%0d/%0d exp=3/20", frame_cnt, last_len); end
  endtask

  task automatic test_reset_mid();
    im_busy = 1;
    for (int i = 0; i < 2; i++) begin
      is_valid = 1; is_data = 32'h300 + i; is_end = 0;
      step();
    end
    is_valid = 0;
    checks++; if (im_valid !== 1'b1 || im_data !== 32'h300) begin errors++; $display("FAIL mid_pre got=%0b/%h exp=1/300", im_valid, im_data); end
    #2 rst_n = 0;
    #1;
    checks++; if (im_valid !== 1'b0 || is_busy !== 1'b0) begin errors++; $display("FAIL mid_async got=%0b/%0b exp=0/0", im_valid, is_busy); end
    checks++; if (frame_cnt !== 16'd0 || last_len !== 24'd0 || dut.pix_cnt !== 24'd0) begin errors++; $display("FAIL mid_stats got=%0d/%0d exp=0/0", frame_cnt, last_len); end
    step();
    rst_n = 1; im_busy = 0;
    is_valid = 1; is_data = 32'h55; is_end = 1;
    step();
    checks++; if (im_valid !== 1'b1 || im_data !== 32'h55 || im_end !== 1'b1) begin errors++; $display("FAIL mid_first got=%0b/%h/%0b exp=1/55/1", im_valid, im_data, im_end); end
    is_valid = 0; is_end = 0;
    step();
    checks++; if (frame_cnt !== 16'd1 || last_len !== 24'd1) begin errors++; $display("FAIL mid_stats2 got=%0d/%0d exp=1/1", frame_cnt, last_len); end
  endtask

  task automatic test_frame_wrap();
    rst_n = 0;
    step();
    rst_n = 1; im_busy = 0;
    for (int i = 0; i < 65537; i++) begin
      is_valid = 1; is_data = i; is_end = 1;
      step();
      if (i == 65535) begin
        checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL fw_max got=%h exp=ffff", frame_cnt); end
      end
    end
    is_valid = 0; is_end = 0;
    step();
    checks++; if (frame_cnt !== 16'd1 || last_len !== 24'd1) begin errors++; $display("FAIL fw_wrap got=%0d/%0d exp=1/1", frame_cnt, last_len); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/image_pipe_core.md
Name: image_pipe_core

Overview:
- Synthesizable DUT-side endpoint of the image pipe stream interface.
- Receives pixel beats on the is_* port with is_busy_out back-pressure, applies a saturating offset, and buffers beats in a DEPTH-entry FIFO.
- Emits beats on the im_* port, honouring the downstream im_busy_in stall.
- Keeps frame and pixel statistics for the testbench and CSR readback.

Parameters:
- DW_IN, 32, input pixel width.
- DW_OUT, 32, output pixel width.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- OFFSET, 0, unsigned constant added to each pixel, DW_IN bits.
- LEN_W, 24, width of the pixel-length counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- is_data_in  in  DW_IN  input pixel.
- is_valid_in  in  1  input beat valid.
- is_end_in  in  1  last pixel of frame; qualified by is_valid_in.
- is_busy_out  out  1  stall to upstream.
- im_data_out  out  DW_OUT  output pixel.
- im_valid_out  out  1  output beat valid.
- im_end_out  out  1  last pixel of frame; qualified by im_valid_out.
- im_busy_in  in  1  stall from downstream.
- frame_cnt  out  16  completed output frames; wraps.
- last_frame_len  out  LEN_W  pixel count of the most recent completed output frame.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n; assertion takes effect immediately, release is synchronous to clk.
- Reset values: count=0, pointers=0, is_busy_out=0, im_valid_out=0, im_end_out=0, im_data_out=0, frame_cnt=0, last_frame_len=0, internal pix_cnt=0.
- Input transfer: happens at a rising edge where is_valid_in=1 and is_busy_out=0.
- is_busy_out: equals (count==DEPTH). It is a decode of registered state only, with no combinational path from any input.
- Upstream obligation: while is_busy_out=1, upstream holds is_valid_in, is_data_in and is_end_in stable.
- Output transfer: happens at a rising edge where im_valid_out=1 and im_busy_in=0.
- im_valid_out: equals (count!=0).
- im_data_out / im_end_out: driven from the FIFO head entry; forced to 0 when count==0.
- Output stability: while im_valid_out=1 and im_busy_in=1, im_* stays stable.
- Transform, applied on write: sum = is_data_in + OFFSET, computed at DW_IN+1 bits.
  - If sum > 2^DW_OUT-1, the stored value is all ones (saturate).
  - Otherwise sum is zero-extended to DW_OUT.
  - is_end_in is stored alongside the data.
- Latency: a beat accepted at edge N appears on im_* right after edge N when the FIFO was empty. There is no combinational in-to-out path.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any occupancy 1..DEPTH-1, and at DEPTH only as a pop (busy blocks the push).
- Pointer width: log2(DEPTH) bits; pointers wrap naturally modulo DEPTH.
- Statistics, updated on each output transfer:
  - pix_cnt increments.
  - If im_end_out=1: last_frame_len <= pix_cnt+1, frame_cnt <= frame_cnt+1 (wraps 0xFFFF->0), pix_cnt <= 0.
  - pix_cnt saturates at 2^LEN_W-1 rather than wrapping.
- Degenerate frames: a beat with end=1 and no preceding beats is a 1-pixel frame, so last_frame_len=1.
- Reset mid-frame: the FIFO contents are discarded and the statistics cleared. After release the block accepts input on the first edge.

Test Plan:
- OFFSET=0, DEPTH=4, im_busy_in=0; send 3 beats 0x10, 0x20, 0x30 with end on the last:
  - im_* shows each beat one edge after acceptance.
  - frame_cnt=1, last_frame_len=3.
  - is_busy_out never asserts.
- OFFSET=5, DW_OUT=8, DW_IN=8; send 0xF0, 0xFA, 0xFF -> outputs 0xF5, 0xFF, 0xFF (saturation).
- Hold im_busy_in=1 and stream 6 beats:
  - is_busy_out asserts after the 4th acceptance.
  - The 5th beat stays held.
  - im_data_out stays at beat 1 throughout.
  - Release im_busy_in -> all 6 beats appear in order with no loss or duplication.
- Full FIFO with im_busy_in toggling 1/0 every cycle and upstream always valid:
  - Sustained push/pop keeps count at 3..4.
  - Order is preserved across pointer wrap for 20 beats.
- Assert rst_n=0 mid-frame with 2 beats queued:
  - im_valid_out, is_busy_out and the counters go to 0 immediately, before the next clock edge.
  - A new 1-beat frame with end=1 after release gives frame_cnt=1, last_frame_len=1.
- Stream 65537 one-beat frames -> frame_cnt wraps to 1.
